// File: rtl/pool2x2_window_gen.sv
// Streaming 2x2 stride-2 window generator for the fp16 max-pool stage.
// One row is buffered; windows leave registered with a valid/ready handshake.
module pool2x2_window_gen #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 24,
  parameter int IMG_H  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] win_a,
  output logic [DATA_W-1:0] win_b,
  output logic [DATA_W-1:0] win_c,
  output logic [DATA_W-1:0] win_d,
  output logic              win_valid,
  input  logic              win_ready,
  output logic              frame_done,
  output logic              busy
);

  localparam int COL_W = $clog2(IMG_W);
  localparam int ROW_W = $clog2(IMG_H);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic {FILL, PAIR} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic [DATA_W-1:0] line_buf [IMG_W];
  logic [DATA_W-1:0] hold_c;

  logic             in_xfer;
  logic             out_xfer;
  logic             col_last;
  logic             row_last;
  logic             new_win;
  logic [COL_W-1:0] col_even;

  assign in_ready = !(win_valid && !win_ready);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = win_valid && win_ready;
  assign col_last = (col_q == COL_LAST);
  assign row_last = (row_q == ROW_LAST);
  assign col_even = col_q & ~COL_W'(1);
  assign new_win  = in_xfer && (state_q == PAIR) && col_q[0];
  assign busy     = (row_q != '0) || (col_q != '0) || win_valid;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: if (in_xfer && col_last) state_d = PAIR;
      PAIR: if (in_xfer && col_last) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      col_q   <= '0;
      row_q   <= '0;
    end else begin
      state_q <= state_d;
      if (in_xfer) begin
        if (col_last) begin
          col_q <= '0;
          row_q <= row_last ? '0 : row_q + ROW_W'(1);
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end
    end
  end

  // Pixel storage carries no reset; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (in_xfer && state_q == FILL) line_buf[col_q] <= in_data;
    if (in_xfer && state_q == PAIR && !col_q[0]) hold_c <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_a      <= '0;
      win_b      <= '0;
      win_c      <= '0;
      win_d      <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= new_win && row_last && col_last;
      if (new_win) begin
        win_a     <= line_buf[col_even];
        win_b     <= line_buf[col_q];
        win_c     <= hold_c;
        win_d     <= in_data;
        win_valid <= 1'b1;
      end else if (out_xfer) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool2x2_window_gen.sv
// Directed bench for pool2x2_window_gen: 4x4 instance for handshake corners,
// default 24x24 instance for a full random frame.
module tb_pool2x2_window_gen;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] c;
    logic [15:0] d;
  } win_t;

  typedef struct {
    int   idx;
    win_t off;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] win_a, win_b, win_c, win_d;
  logic        win_valid;
  logic        win_ready;
  logic        frame_done;
  logic        busy;

  logic [15:0] b_in_data;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [15:0] b_win_a, b_win_b, b_win_c, b_win_d;
  logic        b_win_valid;
  logic        b_win_ready;
  logic        b_frame_done;
  logic        b_busy;

  int   checks = 0;
  int   failures = 0;
  int   fd_cnt = 0;
  win_t got_q[$];
  win_t big_q[$];
  vec_t tab[4];
  logic is_d = 1'b0;
  logic lat_exp = 1'b0;
  logic [15:0] lat_d = '0;
  logic prev_stall = 1'b0;
  logic stop = 1'b0;
  logic [15:0] big_px [576];

  always #5 clk = ~clk;

  pool2x2_window_gen #(.DATA_W(16), .IMG_W(4), .IMG_H(4)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .win_a(win_a), .win_b(win_b), .win_c(win_c), .win_d(win_d),
    .win_valid(win_valid), .win_ready(win_ready),
    .frame_done(frame_done), .busy(busy)
  );

  pool2x2_window_gen u_big (
    .clk(clk), .rst_n(rst_n),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .win_a(b_win_a), .win_b(b_win_b), .win_c(b_win_c), .win_d(b_win_d),
    .win_valid(b_win_valid), .win_ready(b_win_ready),
    .frame_done(b_frame_done), .busy(b_busy)
  );

  always @(negedge clk) begin
    if (!rst_n) begin
      lat_exp = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (lat_exp) begin
        checks++;
        if (!win_valid || win_d !== lat_d) begin
          failures++;
          $display("FAIL latency: win_valid=%b win_d=%h, need 1 and %h",
                   win_valid, win_d, lat_d);
        end
      end
      lat_exp = in_valid && in_ready && is_d;
      lat_d = in_data;
      if (in_ready !== !(win_valid && !win_ready)) begin
        failures++;
        $display("FAIL in_ready: got %b with win_valid=%b win_ready=%b",
                 in_ready, win_valid, win_ready);
      end
      if (frame_done) begin
        fd_cnt++;
        checks++;
        if (!win_valid || win_d[3:0] !== 4'hF || prev_stall) begin
          failures++;
          $display("FAIL frame_done: win_valid=%b win_d=%h stalled=%b",
                   win_valid, win_d, prev_stall);
        end
      end
      if (win_valid && win_ready)
        got_q.push_back({win_a, win_b, win_c, win_d});
      prev_stall = win_valid && !win_ready;
    end
  end

  always @(negedge clk)
    if (rst_n && b_win_valid && b_win_ready)
      big_q.push_back({b_win_a, b_win_b, b_win_c, b_win_d});

  task automatic chk(input string n, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h, need %h", n, got, exp);
    end
  endtask

  task automatic feed(input logic [15:0] d, input logic d_flag,
                      input int gap_pct);
    int n;
    while ($urandom_range(99) < gap_pct) begin
      in_valid = 1'b0;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b1;
    in_data = d;
    is_d = d_flag;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      failures++;
      $display("FAIL feed_timeout: in_ready stuck at %b, need 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    is_d = 1'b0;
  endtask

  task automatic feed_frame(input logic [15:0] base, input int gap_pct,
                            input int cnt);
    for (int p = 0; p < cnt; p++) begin
      int q;
      q = p % 16;
      feed(base + 16'(p), ((q / 4) % 2 == 1) && ((q % 4) % 2 == 1),
           gap_pct);
    end
  endtask

  task automatic drain(input string n);
    int k;
    k = 0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    while (win_valid && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk({n, "_win_valid_idle"}, 64'(win_valid), 64'd0);
    chk({n, "_busy_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic check_wins(input string n, input logic [15:0] base,
                            input int nf);
    chk({n, "_count"}, 64'(got_q.size()), 64'(4 * nf));
    for (int i = 0; i < got_q.size() && i < 4 * nf; i++) begin
      win_t e;
      logic [15:0] fb;
      fb = base + 16'(16 * (i / 4));
      e.a = fb + tab[i % 4].off.a;
      e.b = fb + tab[i % 4].off.b;
      e.c = fb + tab[i % 4].off.c;
      e.d = fb + tab[i % 4].off.d;
      checks++;
      if (got_q[i] !== e) begin
        failures++;
        $display("FAIL %s_win%0d: got %h, need %h", n, i, got_q[i], e);
      end
    end
    got_q.delete();
  endtask

  task automatic stall_first;
    int n;
    n = 0;
    @(negedge clk);
    while (!win_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("stall_first_seen", 64'(win_valid), 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_hold", {win_a, win_b, win_c, win_d},
          {16'h0000, 16'h0001, 16'h0004, 16'h0005});
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    win_ready = 1'b1;
  endtask

  initial begin
    tab[0] = '{0, '{16'h0, 16'h1, 16'h4, 16'h5}};
    tab[1] = '{1, '{16'h2, 16'h3, 16'h6, 16'h7}};
    tab[2] = '{2, '{16'h8, 16'h9, 16'hC, 16'hD}};
    tab[3] = '{3, '{16'hA, 16'hB, 16'hE, 16'hF}};
    for (int i = 0; i < 576; i++) big_px[i] = 16'($urandom);

    rst_n = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    win_ready = 1'b1;
    b_in_valid = 1'b0;
    b_in_data = '0;
    b_win_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_win", {win_a, win_b, win_c, win_d}, 64'd0);
    chk("rst_win_valid", 64'(win_valid), 64'd0);
    chk("rst_frame_done", 64'(frame_done), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    fd_cnt = 0;
    feed_frame(16'h0000, 0, 16);
    drain("t1");
    check_wins("t1", 16'h0000, 1);
    chk("t1_frame_done", 64'(fd_cnt), 64'd1);

    fd_cnt = 0;
    win_ready = 1'b0;
    fork
      feed_frame(16'h0000, 0, 16);
      stall_first();
    join
    drain("t2");
    check_wins("t2", 16'h0000, 1);
    chk("t2_frame_done", 64'(fd_cnt), 64'd1);

    fd_cnt = 0;
    feed_frame(16'h1000, 50, 32);
    drain("t3");
    check_wins("t3", 16'h1000, 2);
    chk("t3_frame_done", 64'(fd_cnt), 64'd2);

    feed_frame(16'h0200, 0, 7);
    rst_n = 1'b0;
    #1;
    chk("t4_rst_win_valid", 64'(win_valid), 64'd0);
    chk("t4_rst_busy", 64'(busy), 64'd0);
    chk("t4_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    got_q.delete();
    fd_cnt = 0;
    @(posedge clk);
    #1;
    feed_frame(16'h0100, 0, 16);
    drain("t4");
    check_wins("t4", 16'h0100, 1);
    chk("t4_frame_done", 64'(fd_cnt), 64'd1);

    fd_cnt = 0;
    stop = 1'b0;
    fork
      begin
        feed_frame(16'h2000, 0, 16);
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          @(posedge clk);
          #1;
          win_ready = ~win_ready;
        end
      end
    join
    win_ready = 1'b1;
    drain("t5");
    check_wins("t5", 16'h2000, 1);
    chk("t5_frame_done", 64'(fd_cnt), 64'd1);

    for (int p = 0; p < 576; p++) begin
      b_in_data = big_px[p];
      b_in_valid = 1'b1;
      @(negedge clk);
      if (!b_in_ready) begin
        failures++;
        $display("FAIL big_in_ready: got 0 at pixel %0d, need 1", p);
      end
      @(posedge clk);
      #1;
    end
    b_in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("big_count", 64'(big_q.size()), 64'd144);
    for (int k = 0; k < big_q.size() && k < 144; k++) begin
      int r, c, t;
      win_t e;
      r = k / 12;
      c = k % 12;
      t = 2 * r * 24 + 2 * c;
      e = {big_px[t], big_px[t + 1], big_px[t + 24], big_px[t + 25]};
      checks++;
      if (big_q[k] !== e) begin
        failures++;
        $display("FAIL big_win%0d: got %h, need %h", k, big_q[k], e);
      end
    end
    chk("big_busy", 64'(b_busy), 64'd0);
    chk("big_win_valid", 64'(b_win_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
